romulus_round_sched: RTL
========================

Name: romulus_round_sched

Overview:
- Round scheduler for the SKINNY-128-384+ tweakable block cipher inside the Romulus datapath.
- On each accepted start it sequences every round of one TBC call and drives the state/tweakey enables, the per-clock round-constant bus and the sub-round phase select.
- Owns the 56-bit Romulus block-counter LFSR, stepped on request from the top-level API FSM.
- Sits between the API control FSM and the datapath.

Parameters:
- NUM_RNDS, 40, total SKINNY rounds per TBC call.
- RNDS_PER_CLK, 1, rounds unrolled per clock; one of 1, 2, 4, 5, 8.
- CLKS_PER_RND, 1, clocks per round (serialised datapath); one of 1, 2, 4. Must be 1 whenever RNDS_PER_CLK > 1.
- CNTW, 6, round-constant width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request one TBC call; accepted only when idle is 1.
- abort  in  1  synchronous return to IDLE.
- done_ack  in  1  consumer acknowledges done.
- cnt_rst  in  1  load block counter with 1.
- cnt_inc  in  1  step block-counter LFSR once.
- idle  out  1  scheduler is in IDLE.
- sen  out  1  state-register enable.
- ten  out  1  tweakey-register enable.
- enrnd  out  CLKS_PER_RND  one-hot sub-round phase.
- constant  out  CNTW*RNDS_PER_CLK  round constants. Lane 0 (LSBs) is the lowest-numbered round this clock.
- done  out  1  TBC call complete; held until acknowledged.
- counter  out  56  block-counter LFSR value.

Behaviour:
- Reset (async, rst=1) forces:
  - state = IDLE, rc = 0, phase = 0, round count = 0.
  - idle = 1, sen = ten = done = 0, enrnd = 1 (bit 0), counter = 56'h1.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1. Start is accepted in IDLE only and ignored in RUN/DONE.
  - RUN -> DONE on the clock where the last round's last phase executes.
  - DONE -> IDLE on done_ack=1. The scheduler does not accept start in the same cycle.
  - abort=1 in any state -> IDLE next clock; rc/phase/count cleared, done deasserted. abort has priority over start and done_ack.
- RUN outputs:
  - sen = ten = 1 every RUN cycle; 0 in IDLE and DONE.
  - RUN lasts exactly (NUM_RNDS/RNDS_PER_CLK)*CLKS_PER_RND cycles, which is 40 for the defaults.
  - done rises the cycle after the final RUN cycle.
- Round-constant LFSR: rc_next = {rc[4:0], rc[5] ^ rc[4] ^ 1}.
  - Each RUN clock, lane k of constant shows the rc value after (r+k+1) updates, where r is the count of completed rounds.
  - The first round's constant is 6'h01, so the sequence runs 01, 03, 07, 0F, 1F, 3E, 3D, 3B, ...
  - Combinationally derive RNDS_PER_CLK successive values from the registered rc.
  - Register advance: by RNDS_PER_CLK steps, only on the final phase of a round.
  - constant is held at the lane values for round 0 while in IDLE; don't-care in DONE.
- enrnd:
  - One-hot, rotates left each RUN clock and wraps on the final phase.
  - Returns to bit 0 in IDLE.
  - Is constant 1 when CLKS_PER_RND = 1.
- Round counter width: clog2(NUM_RNDS+1). Compare against NUM_RNDS - RNDS_PER_CLK to detect the last step; no overflow past NUM_RNDS.
- Block counter:
  - Galois LFSR for x^56 + x^7 + x^4 + x^2 + 1.
  - cnt_inc step: next = {counter[54:0], 1'b0} ^ (counter[55] ? 56'h95 : 0).
  - cnt_rst loads 56'h1 and has priority over cnt_inc.
  - Counter operations are legal in any FSM state and are unaffected by abort.
- Simultaneous start and abort in IDLE: stay IDLE.

Decomposition:
- Shared package (romulus_config_pkg):
  - NUM_RNDS, RNDS_PER_CLK, CLKS_PER_RND, CNTW.
  - FSM state encodings.
  - RC_INIT (6'h00), CNT_INIT (56'h1), CNT_POLY (56'h95).
- One sub-module, romulus_rc_lfsr: combinational next-N-constant generator, parameterised by step count. Used both for the constant lanes and for the register advance.
- Block-counter LFSR stays inline.

Test Plan:
- Defaults; reset then pulse start -> idle falls next clock; exactly 40 RUN cycles with sen=ten=1; constant lane 0 = 01, 03, 07, 0F, 1F, 3E, ...; the 40th constant is 6'h1A; done rises on the next clock and holds until done_ack, then idle=1.
- RNDS_PER_CLK=4 -> 10 RUN cycles; first constant = {0F,07,03,01}, second = {3B,3D,3E,1F}; done after cycle 10.
- CLKS_PER_RND=2 -> 80 RUN cycles; enrnd alternates 01/10; constant changes only after enrnd=10 cycles.
- abort at RUN cycle 17, and start pulses during RUN/DONE -> back to IDLE next clock, no done; ignored starts cause no restart; a fresh start then yields the full 01-first sequence.
- cnt_rst, then 56 cnt_inc -> counter = 56'h95; cnt_rst+cnt_inc together -> 56'h1; async rst mid-RUN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/romulus_config_pkg.sv
// Shared configuration for the Romulus SKINNY-128-384+ round scheduler:
// default geometry, FSM encodings and LFSR constants.
package romulus_config_pkg;

  localparam int unsigned NUM_RNDS     = 40;
  localparam int unsigned RNDS_PER_CLK = 1;
  localparam int unsigned CLKS_PER_RND = 1;
  localparam int unsigned CNTW         = 6;
  localparam int unsigned CNT_W        = 56;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNTW-1:0]  RC_INIT  = 6'h00;
  localparam logic [CNT_W-1:0] CNT_INIT = 56'h1;
  // Galois feedback taps for x^56 + x^7 + x^4 + x^2 + 1
  localparam logic [CNT_W-1:0] CNT_POLY = 56'h95;

endpackage

// File: rtl/romulus_rc_lfsr.sv
// Combinational SKINNY round-constant generator: lane k holds the value
// of the 6-bit constant LFSR after k+1 updates of rc_in.
module romulus_rc_lfsr #(
  parameter int unsigned CNTW  = 6,
  parameter int unsigned STEPS = 1
) (
  input  logic [CNTW-1:0]       rc_in,
  output logic [CNTW*STEPS-1:0] lanes
);

  logic [CNTW-1:0] v;

  always_comb begin
    v     = rc_in;
    lanes = '0;
    for (int unsigned k = 0; k < STEPS; k++) begin
      v = {v[CNTW-2:0], v[CNTW-1] ^ v[CNTW-2] ^ 1'b1};
      lanes[k*CNTW +: CNTW] = v;
    end
  end

endmodule

// File: rtl/romulus_round_sched.sv
// Round scheduler for one SKINNY-128-384+ TBC call: sequences rounds and
// sub-round phases, drives round constants, owns the 56-bit block counter.
module romulus_round_sched
  import romulus_config_pkg::ST_IDLE, romulus_config_pkg::ST_RUN,
         romulus_config_pkg::ST_DONE, romulus_config_pkg::RC_INIT,
         romulus_config_pkg::CNT_INIT, romulus_config_pkg::CNT_POLY;
#(
  parameter int unsigned NUM_RNDS     = romulus_config_pkg::NUM_RNDS,
  parameter int unsigned RNDS_PER_CLK = romulus_config_pkg::RNDS_PER_CLK,
  parameter int unsigned CLKS_PER_RND = romulus_config_pkg::CLKS_PER_RND,
  parameter int unsigned CNTW         = romulus_config_pkg::CNTW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         done_ack,
  input  logic                         cnt_rst,
  input  logic                         cnt_inc,
  output logic                         idle,
  output logic                         sen,
  output logic                         ten,
  output logic [CLKS_PER_RND-1:0]      enrnd,
  output logic [CNTW*RNDS_PER_CLK-1:0] constant,
  output logic                         done,
  output logic [55:0]                  counter
);

  localparam int unsigned RCW    = $clog2(NUM_RNDS + 1);
  localparam int unsigned LANE_W = CNTW * RNDS_PER_CLK;
  localparam logic [RCW-1:0]          LAST_CNT   = RCW'(NUM_RNDS - RNDS_PER_CLK);
  localparam logic [RCW-1:0]          STEP_CNT   = RCW'(RNDS_PER_CLK);
  localparam logic [CLKS_PER_RND-1:0] ENRND_INIT = CLKS_PER_RND'(1);

  logic [1:0]              state, state_nxt;
  logic [CNTW-1:0]         rc, rc_nxt, rc_adv;
  logic [RCW-1:0]          rnd_cnt, rnd_cnt_nxt;
  logic [CLKS_PER_RND-1:0] enrnd_nxt, enrnd_rot;
  logic [LANE_W-1:0]       lanes;
  logic                    last_phase;

  romulus_rc_lfsr #(
    .CNTW  (CNTW),
    .STEPS (RNDS_PER_CLK)
  ) u_rc_lfsr (
    .rc_in (rc),
    .lanes (lanes)
  );

  // Top lane is the constant after a full clock's worth of rounds
  assign rc_adv     = lanes[LANE_W-1 -: CNTW];
  assign constant   = lanes;
  assign last_phase = enrnd[CLKS_PER_RND-1];

  if (CLKS_PER_RND == 1) begin : g_rot_single
    assign enrnd_rot = enrnd;
  end else begin : g_rot_multi
    assign enrnd_rot = {enrnd[CLKS_PER_RND-2:0], enrnd[CLKS_PER_RND-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rc      <= CNTW'(RC_INIT);
      rnd_cnt <= '0;
      enrnd   <= ENRND_INIT;
      idle    <= 1'b1;
      sen     <= 1'b0;
      ten     <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      rc      <= rc_nxt;
      rnd_cnt <= rnd_cnt_nxt;
      enrnd   <= enrnd_nxt;
      idle    <= (state_nxt == ST_IDLE);
      sen     <= (state_nxt == ST_RUN);
      ten     <= (state_nxt == ST_RUN);
      done    <= (state_nxt == ST_DONE);
    end
  end

  always_comb begin
    state_nxt   = state;
    rc_nxt      = rc;
    rnd_cnt_nxt = rnd_cnt;
    enrnd_nxt   = enrnd;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        enrnd_nxt = enrnd_rot;
        if (last_phase) begin
          rc_nxt      = rc_adv;
          rnd_cnt_nxt = rnd_cnt + STEP_CNT;
          if (rnd_cnt == LAST_CNT) state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (done_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
    // Anything headed to IDLE restarts from round 0, phase 0
    if (state_nxt == ST_IDLE) begin
      rc_nxt      = CNTW'(RC_INIT);
      rnd_cnt_nxt = '0;
      enrnd_nxt   = ENRND_INIT;
    end
  end

  // Block counter runs independently of the round FSM and of abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= CNT_INIT;
    end else if (cnt_rst) begin
      counter <= CNT_INIT;
    end else if (cnt_inc) begin
      counter <= {counter[54:0], 1'b0} ^ (counter[55] ? CNT_POLY : 56'h0);
    end
  end

endmodule
